wdt_kick_generator: RTL
=======================

// Module: wdt_kick_generator
// PURPOSE
//  Servicing side of the watchdog interface. Issues periodic one-cycle kicks on wd_kick (drives the watchdog's wd_en).
//  Kicks continue only while the supervised logic proves liveness via heartbeat pulses; on heartbeat starvation, kicking
//  stops so the watchdog fires. Also counts watchdog resets (wd_rst_i) for diagnostics.
// PARAMETERS
//  KICK_PERIOD  100  cycles between kicks; >=2 and strictly below the watchdog wait_time
//  HB_TIMEOUT   400  cycles without heartbeat before declaring starvation; >=1
// PORTS
//  clk        in   1   clock; all logic on posedge clk
//  rst        in   1   reset, synchronous, active-high
//  en         in   1   enable kicking; 0 = IDLE, no kicks
//  heartbeat  in   1   liveness pulse from supervised logic; any high cycle counts
//  wd_rst_i   in   1   watchdog rst_o, level; rising edges counted
//  wd_kick    out  1   registered kick pulse, exactly 1 cycle wide
//  starving   out  1   registered; 1 while in STARVE
//  rst_cnt    out  8   saturating count of wd_rst_i rising edges
//  state_o    out  2   current FSM state (IDLE=0, ARMED=1, STARVE=2)
// BEHAVIOUR
//  - rst (sync): state=IDLE, wd_kick=0, starving=0, rst_cnt=0, kick_cnt=0, hb_cnt=0, wd_rst_q=0. Mid-operation rst aborts any pending kick.
//  - IDLE: wd_kick=0. en=1 -> ARMED next cycle, kick_cnt=0, hb_cnt=0.
//  - ARMED: kick_cnt+1 per cycle; at kick_cnt==KICK_PERIOD-1, wd_kick=1 next cycle, kick_cnt wraps to 0.
//    First kick KICK_PERIOD cycles after ARMED entry; then every KICK_PERIOD cycles exactly.
//    hb_cnt+1 per cycle; heartbeat=1 clears it to 0. At hb_cnt==HB_TIMEOUT-1 with heartbeat=0 -> STARVE.
//  - STARVE: wd_kick=0, starving=1, kick_cnt held 0.
//    heartbeat=1 -> ARMED, hb_cnt=0, kick_cnt=0 (see CONFIGURATION).
//  - en=0 in any state -> IDLE next cycle; wd_kick=0 that cycle; counters cleared.
//  - Simultaneous events: heartbeat on the timeout cycle -> stays ARMED. Timeout on the kick cycle -> STARVE, no kick.
//    en=0 dominates all except rst.
//  - wd_rst_i: registered to wd_rst_q; rising edge = wd_rst_i & ~wd_rst_q. Each edge increments rst_cnt, saturating at 255.
//    Edge counting runs in every state, including IDLE. wd_rst_i does not alter the FSM.
//  - Widths: kick_cnt $clog2(KICK_PERIOD); hb_cnt $clog2(HB_TIMEOUT+1). Counters never exceed terminal values.
// CONFIGURATION
//  WDT_STARVE_LATCH_EN defined: STARVE is sticky; heartbeat is ignored; exit only via rst or en=0 (-> IDLE).
//  Undefined: heartbeat in STARVE returns to ARMED as above.
// STRUCTURE
//  Package wdt_pkg: state enum wdt_state_t {IDLE, ARMED, STARVE}, localparam RST_CNT_W=8, RST_CNT_MAX=255.
//  Sub-module wdt_edge_det: 1-bit synchronous rising-edge detector with sync active-high rst, used for wd_rst_i.
//  Single FSM block plus kick/heartbeat counters in the top module.
// TESTING (KICK_PERIOD=8, HB_TIMEOUT=20)
//  1. rst, en=1, heartbeat every 5 cycles for 100 cycles -> ARMED; wd_kick 1-cycle pulses every 8 cycles, first 8 cycles after ARMED; starving=0.
//  2. en=1, heartbeat never -> 2 kicks, then STARVE 20 cycles after ARMED entry; starving=1; no further kicks.
//  3. From STARVE, heartbeat=1 for 1 cycle -> ARMED, next kick 8 cycles later. With WDT_STARVE_LATCH_EN: stays STARVE, no kicks.
//  4. 300 rising edges on wd_rst_i (each 2 cycles high, 2 low) -> rst_cnt=255; a level held high 50 cycles adds only 1.
//  5. en dropped 5 cycles into a period -> IDLE next cycle, no kick. rst asserted mid-ARMED -> all outputs 0 next cycle.
//  6. heartbeat on the exact timeout cycle -> stays ARMED. Timeout coinciding with kick cycle -> STARVE, wd_kick stays 0.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog kick generator.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STARVE = 2'd2
    } wdt_state_t;

    localparam int             RST_CNT_W   = 8;
    localparam logic [RST_CNT_W-1:0] RST_CNT_MAX = 8'd255;

    // Increment that sticks at the top of the range.
    function automatic logic [RST_CNT_W-1:0] sat_inc(input logic [RST_CNT_W-1:0] v);
        return (v == RST_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wdt_edge_det.sv
// One-bit synchronous rising-edge detector; rise is combinational from d and the
// registered previous sample.
module wdt_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    // Hold last sample of d; reset forces "was low" so a high input after reset counts.
    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/wdt_kick_generator.sv
// Watchdog servicing side: periodic one-cycle kicks while heartbeats keep arriving,
// stops kicking on heartbeat starvation, counts watchdog resets.
// Build option: WDT_STARVE_LATCH_EN makes STARVE sticky (heartbeat ignored there).
module wdt_kick_generator
    import wdt_pkg::*;
#(
    parameter int KICK_PERIOD = 100,
    parameter int HB_TIMEOUT  = 400
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 heartbeat,
    input  logic                 wd_rst_i,
    output logic                 wd_kick,
    output logic                 starving,
    output logic [RST_CNT_W-1:0] rst_cnt,
    output logic [1:0]           state_o
);

    localparam int KW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
    localparam int HW = $clog2(HB_TIMEOUT + 1);
    localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIOD - 1);
    localparam logic [HW-1:0] HB_LAST   = HW'(HB_TIMEOUT - 1);

    wdt_state_t    state;
    logic [KW-1:0] kick_cnt;
    logic [HW-1:0] hb_cnt;
    logic          wd_rise;

    wdt_edge_det u_rst_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (wd_rst_i),
        .rise (wd_rise)
    );

    // FSM with kick-period and heartbeat-age counters; en=0 wins over everything but rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wd_kick  <= 1'b0;
            starving <= 1'b0;
            kick_cnt <= '0;
            hb_cnt   <= '0;
        end else begin
            wd_kick  <= 1'b0;
            starving <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                kick_cnt <= '0;
                hb_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ARMED;
                        kick_cnt <= '0;
                        hb_cnt   <= '0;
                    end
                    ARMED: begin
                        // Timeout beats a coincident kick: the watchdog must be left to fire.
                        if (!heartbeat && hb_cnt == HB_LAST) begin
                            state    <= STARVE;
                            starving <= 1'b1;
                            kick_cnt <= '0;
                            hb_cnt   <= '0;
                        end else begin
                            hb_cnt <= heartbeat ? '0 : hb_cnt + 1'b1;
                            if (kick_cnt == KICK_LAST) begin
                                wd_kick  <= 1'b1;
                                kick_cnt <= '0;
                            end else begin
                                kick_cnt <= kick_cnt + 1'b1;
                            end
                        end
                    end
                    STARVE: begin
                        kick_cnt <= '0;
`ifdef WDT_STARVE_LATCH_EN
                        starving <= 1'b1;
`else
                        if (heartbeat) begin
                            state  <= ARMED;
                            hb_cnt <= '0;
                        end else begin
                            starving <= 1'b1;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Saturating count of watchdog reset assertions, independent of FSM state.
    always_ff @(posedge clk) begin
        if (rst)          rst_cnt <= '0;
        else if (wd_rise) rst_cnt <= sat_inc(rst_cnt);
    end

    assign state_o = state;

endmodule
